// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: sequences the HPS ROM download into the shared program/graphics
// memory port and arbitrates that port between download writes and CPU reads.
// Keeps the core in reset during a download and for a settle period afterwards.
module rom_dl_arbiter #(
   parameter int                ADDR_W   = 17,
   parameter logic [ADDR_W-1:0] REG0_END = 17'h00FFF,
   parameter logic [ADDR_W-1:0] REG1_END = 17'h017FF,
   parameter logic [ADDR_W-1:0] REG2_END = 17'h01FFF,
   parameter logic [ADDR_W-1:0] REG3_END = 17'h0211F,
   parameter int                SETTLE   = 16,
   parameter int                STARVE   = 8
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              dn_download,
   input  logic              dn_wr,
   input  logic [ADDR_W-1:0] dn_addr,
   input  logic [7:0]        dn_data,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ack,
   output logic              cpu_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   output logic [3:0]        mem_sel,
   output logic              core_reset_n,
   output logic              oob_err,
   output logic [ADDR_W-1:0] byte_cnt
);

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_LOAD,
      ST_FLUSH,
      ST_POST,
      ST_RUN
   } state_t;

   state_t            state_reg, state_next;
   logic [7:0]        post_cnt_reg, post_cnt_next;
   logic [7:0]        wait_cnt_reg, wait_cnt_next;
   logic              dl_prev_reg;

   // two-entry write queue
   logic [ADDR_W-1:0] fifo_addr_reg [2];
   logic [7:0]        fifo_data_reg [2];
   logic [1:0]        fifo_cnt_reg, fifo_cnt_next;
   logic              rd_ptr_reg, wr_ptr_reg;

   logic              core_reset_n_reg, core_reset_n_next;
   logic              cpu_ack_reg, cpu_ack_next;
   logic              cpu_wait_reg, cpu_wait_next;
   logic              mem_we_reg, mem_we_next;
   logic [3:0]        mem_sel_reg, mem_sel_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [7:0]        mem_din_reg, mem_din_next;
   logic              oob_err_reg, oob_err_next;
   logic [ADDR_W-1:0] byte_cnt_reg, byte_cnt_next;

   logic              dl_rise, in_range, accept, drop, fifo_has, wr_avail;
   logic              grant_wr, grant_cpu, preempt, push, pop;
   logic [ADDR_W-1:0] head_addr;
   logic [7:0]        head_data;
   logic [ADDR_W+3:0] wr_dec, rd_dec;

   // Linear address -> {one-hot region select, region-local address}; zero when out of range.
   function automatic logic [ADDR_W+3:0] region_decode(input logic [ADDR_W-1:0] a);
      logic [3:0]        sel;
      logic [ADDR_W-1:0] loc;
      sel = 4'b0000;
      loc = '0;
      if (a <= REG0_END) begin
         sel = 4'b0001;
         loc = a;
      end else if (a <= REG1_END) begin
         sel = 4'b0010;
         loc = a - REG0_END - ADDR_W'(1);
      end else if (a <= REG2_END) begin
         sel = 4'b0100;
         loc = a - REG1_END - ADDR_W'(1);
      end else if (a <= REG3_END) begin
         sel = 4'b1000;
         loc = a - REG2_END - ADDR_W'(1);
      end
      return {sel, loc};
   endfunction

   // Port arbitration: outside RUN the write queue owns the port; in RUN the CPU wins
   // until the waiting write has been passed over STARVE times.
   always_comb begin
      dl_rise   = dn_download && !dl_prev_reg;
      in_range  = (dn_addr <= REG3_END);
      accept    = dn_wr && in_range && (fifo_cnt_reg != 2'd2);
      drop      = dn_wr && !accept;
      fifo_has  = (fifo_cnt_reg != 2'd0);
      wr_avail  = fifo_has || accept;
      head_addr = fifo_has ? fifo_addr_reg[rd_ptr_reg] : dn_addr;
      head_data = fifo_has ? fifo_data_reg[rd_ptr_reg] : dn_data;

      grant_wr      = 1'b0;
      grant_cpu     = 1'b0;
      preempt       = 1'b0;
      wait_cnt_next = '0;
      if (state_reg == ST_RUN) begin
         if (wr_avail) begin
            if (!cpu_req) begin
               grant_wr = 1'b1;
            end else if (wait_cnt_reg >= 8'(STARVE)) begin
               grant_wr = 1'b1;
               preempt  = 1'b1;
            end else begin
               grant_cpu     = 1'b1;
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end else if (cpu_req) begin
            grant_cpu = 1'b1;
         end
      end else begin
         grant_wr = wr_avail;
      end

      // an incoming byte granted straight away bypasses the queue
      push = accept && !(grant_wr && !fifo_has);
      pop  = grant_wr && fifo_has;
      fifo_cnt_next = fifo_cnt_reg;
      if (push && !pop) begin
         fifo_cnt_next = fifo_cnt_reg + 2'd1;
      end else if (pop && !push) begin
         fifo_cnt_next = fifo_cnt_reg - 2'd1;
      end
   end

   // Next values for the registered memory-port and status outputs.
   always_comb begin
      wr_dec        = region_decode(head_addr);
      rd_dec        = region_decode(cpu_addr);
      cpu_ack_next  = grant_cpu;
      cpu_wait_next = preempt;
      mem_we_next   = grant_wr;
      mem_sel_next  = 4'b0000;
      mem_addr_next = mem_addr_reg;
      mem_din_next  = mem_din_reg;
      if (grant_wr) begin
         mem_sel_next  = wr_dec[ADDR_W+3:ADDR_W];
         mem_addr_next = wr_dec[ADDR_W-1:0];
         mem_din_next  = head_data;
      end else if (grant_cpu) begin
         mem_sel_next  = rd_dec[ADDR_W+3:ADDR_W];
         mem_addr_next = rd_dec[ADDR_W-1:0];
      end

      byte_cnt_next = dl_rise ? '0 : byte_cnt_reg;
      if (accept) begin
         byte_cnt_next = byte_cnt_next + ADDR_W'(1);
      end
      oob_err_next = (dl_rise ? 1'b0 : oob_err_reg) | drop;
   end

   // Sequencer next state: download rise always wins, then drain, settle and run.
   always_comb begin
      state_next    = state_reg;
      post_cnt_next = post_cnt_reg;
      if (dl_rise) begin
         state_next = ST_LOAD;
      end else begin
         case (state_reg)
            ST_HOLD: begin
               state_next    = ST_POST;
               post_cnt_next = 8'(SETTLE);
            end
            ST_LOAD: begin
               if (!dn_download) begin
                  state_next = ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (fifo_cnt_next == 2'd0) begin
                  state_next    = ST_POST;
                  post_cnt_next = 8'(SETTLE);
               end
            end
            ST_POST: begin
               if (post_cnt_reg <= 8'd1) begin
                  state_next    = ST_RUN;
                  post_cnt_next = 8'd0;
               end else begin
                  post_cnt_next = post_cnt_reg - 8'd1;
               end
            end
            ST_RUN: begin
               state_next = ST_RUN;
            end
            default: begin
               state_next = ST_HOLD;
            end
         endcase
      end
      core_reset_n_next = (state_next == ST_RUN);
   end

   // State, queue and output registers; reset returns everything to idle with the queue empty.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg        <= ST_HOLD;
         post_cnt_reg     <= '0;
         wait_cnt_reg     <= '0;
         dl_prev_reg      <= 1'b0;
         fifo_cnt_reg     <= '0;
         rd_ptr_reg       <= 1'b0;
         wr_ptr_reg       <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_addr_reg[i] <= '0;
            fifo_data_reg[i] <= '0;
         end
         core_reset_n_reg <= 1'b0;
         cpu_ack_reg      <= 1'b0;
         cpu_wait_reg     <= 1'b0;
         mem_we_reg       <= 1'b0;
         mem_sel_reg      <= 4'b0000;
         mem_addr_reg     <= '0;
         mem_din_reg      <= '0;
         oob_err_reg      <= 1'b0;
         byte_cnt_reg     <= '0;
      end else begin
         state_reg        <= state_next;
         post_cnt_reg     <= post_cnt_next;
         wait_cnt_reg     <= wait_cnt_next;
         dl_prev_reg      <= dn_download;
         fifo_cnt_reg     <= fifo_cnt_next;
         rd_ptr_reg       <= rd_ptr_reg ^ pop;
         wr_ptr_reg       <= wr_ptr_reg ^ push;
         if (push) begin
            fifo_addr_reg[wr_ptr_reg] <= dn_addr;
            fifo_data_reg[wr_ptr_reg] <= dn_data;
         end
         core_reset_n_reg <= core_reset_n_next;
         cpu_ack_reg      <= cpu_ack_next;
         cpu_wait_reg     <= cpu_wait_next;
         mem_we_reg       <= mem_we_next;
         mem_sel_reg      <= mem_sel_next;
         mem_addr_reg     <= mem_addr_next;
         mem_din_reg      <= mem_din_next;
         oob_err_reg      <= oob_err_next;
         byte_cnt_reg     <= byte_cnt_next;
      end
   end

   assign core_reset_n = core_reset_n_reg;
   assign cpu_ack      = cpu_ack_reg;
   assign cpu_wait     = cpu_wait_reg;
   assign mem_we       = mem_we_reg;
   assign mem_sel      = mem_sel_reg;
   assign mem_addr     = mem_addr_reg;
   assign mem_din      = mem_din_reg;
   assign oob_err      = oob_err_reg;
   assign byte_cnt     = byte_cnt_reg;

endmodule
